// File: rtl/motor_driver.sv
// motor_driver: dual H-bridge driver for a differential-drive robot.
//
// Takes a one-hot motion command (asynchronous to clk), synchronises it,
// and drives the left bridge (in1/in2/en_a) and right bridge (in3/in4/en_b).
// Speed is applied as PWM on the enables. Every direction change passes
// through a coast dead-time so that no bridge leg reverses while energised.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   motiondir  one-hot command: 0001 fwd, 0010 back, 0100 right, 1000 left, 0000 stop
//   duty       PWM duty; enables high while pwm_cnt < duty
//   in1..in4   bridge legs (left fwd, left rev, right fwd, right rev)
//   en_a/en_b  left/right bridge PWM enables
//   state      00 IDLE, 01 RUN, 10 COAST
//   busy       high while in COAST
module motor_driver #(
  parameter int PWM_BITS = 8,
  parameter int DEADTIME = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          motiondir,
  input  logic [PWM_BITS-1:0] duty,
  output logic                in1,
  output logic                in2,
  output logic                in3,
  output logic                in4,
  output logic                en_a,
  output logic                en_b,
  output logic [1:0]          state,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    COAST = 2'b10
  } state_t;

  localparam logic [3:0]  CMD_STOP  = 4'b0000;
  localparam logic [3:0]  CMD_FWD   = 4'b0001;
  localparam logic [3:0]  CMD_BACK  = 4'b0010;
  localparam logic [3:0]  CMD_RIGHT = 4'b0100;
  localparam logic [3:0]  CMD_LEFT  = 4'b1000;
  localparam logic [19:0] DT_RELOAD = 20'(DEADTIME - 1);
  localparam logic [PWM_BITS-1:0] PWM_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};

  // Anything other than the five legal codes is treated as stop.
  function automatic logic [3:0] legalize(input logic [3:0] c);
    case (c)
      CMD_FWD, CMD_BACK, CMD_RIGHT, CMD_LEFT: legalize = c;
      default:                                legalize = CMD_STOP;
    endcase
  endfunction

  // Leg pattern {in1,in2,in3,in4}; no pattern energises both legs of a bridge.
  function automatic logic [3:0] leg_map(input logic [3:0] c);
    case (c)
      CMD_FWD:   leg_map = 4'b1010;
      CMD_BACK:  leg_map = 4'b0101;
      CMD_RIGHT: leg_map = 4'b1001;
      CMD_LEFT:  leg_map = 4'b0110;
      default:   leg_map = 4'b0000;
    endcase
  endfunction

  logic [3:0]          sync1_r, sync2_r, dec_prev_r, active_r;
  logic [19:0]         dt_cnt_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  state_t              state_r;
  logic [3:0]          legs_r;
  logic                en_r, busy_r;

  logic [3:0]          dec_s, nxt_active_s;
  logic [19:0]         nxt_cnt_s;
  state_t              nxt_state_s;

  assign dec_s = legalize(sync2_r);

  // Next-state, active command and dead-time counter.
  always_comb begin
    nxt_state_s  = state_r;
    nxt_active_s = active_r;
    nxt_cnt_s    = dt_cnt_r;
    case (state_r)
      IDLE: begin
        if (dec_s != CMD_STOP) begin
          nxt_active_s = dec_s;
          nxt_state_s  = RUN;
        end else begin
          nxt_state_s  = IDLE;
        end
      end
      RUN: begin
        if (dec_s != active_r) begin
          nxt_state_s = COAST;
          nxt_cnt_s   = DT_RELOAD;
        end else begin
          nxt_state_s = RUN;
        end
      end
      COAST: begin
        // A change in the command restarts the full dead-time, even at count 0.
        if (dec_s != dec_prev_r) begin
          nxt_cnt_s = DT_RELOAD;
        end else if (dt_cnt_r == 20'd0) begin
          nxt_active_s = dec_s;
          nxt_state_s  = (dec_s == CMD_STOP) ? IDLE : RUN;
        end else begin
          nxt_cnt_s = dt_cnt_r - 20'd1;
        end
      end
      default: begin
        nxt_state_s  = IDLE;
        nxt_active_s = CMD_STOP;
        nxt_cnt_s    = 20'd0;
      end
    endcase
  end

  // Synchroniser, FSM state, counters and output registers.
  // Outputs are registered from the next-state values so that legs appear
  // on the same edge as the state change (third edge after motiondir moves).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r    <= 4'b0000;
      sync2_r    <= 4'b0000;
      dec_prev_r <= 4'b0000;
      active_r   <= CMD_STOP;
      dt_cnt_r   <= 20'd0;
      pwm_cnt_r  <= '0;
      state_r    <= IDLE;
      legs_r     <= 4'b0000;
      en_r       <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      sync1_r    <= motiondir;
      sync2_r    <= sync1_r;
      dec_prev_r <= dec_s;
      active_r   <= nxt_active_s;
      dt_cnt_r   <= nxt_cnt_s;
      pwm_cnt_r  <= pwm_cnt_r + PWM_ONE;
      state_r    <= nxt_state_s;
      legs_r     <= (nxt_state_s == RUN) ? leg_map(nxt_active_s) : 4'b0000;
      en_r       <= (nxt_state_s == RUN) && (pwm_cnt_r < duty);
      busy_r     <= (nxt_state_s == COAST);
    end
  end

  assign in1   = legs_r[3];
  assign in2   = legs_r[2];
  assign in3   = legs_r[1];
  assign in4   = legs_r[0];
  assign en_a  = en_r;
  assign en_b  = en_r;
  assign state = state_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_motor_driver.sv
// Self-checking bench for motor_driver with DEADTIME=4, PWM_BITS=8.
module tb_motor_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] motiondir;
  logic [7:0] duty;
  logic       in1, in2, in3, in4, en_a, en_b, busy;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  motor_driver #(.PWM_BITS(8), .DEADTIME(4)) dut (
    .clk(clk), .reset(reset), .motiondir(motiondir), .duty(duty),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .en_a(en_a), .en_b(en_b), .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cmd;
    logic [3:0] legs;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] legs();
    return {in1, in2, in3, in4};
  endfunction

  // Counts consecutive COAST samples (bounded), checking outputs while coasting.
  task automatic count_coast(output int n);
    n = 0;
    while (state == 2'b10 && n < 40) begin
      chk("coast_busy", busy, 1'b1);
      chk("coast_legs", legs(), 4'b0000);
      chk("coast_en", {en_a, en_b}, 2'b00);
      n++;
      tick();
    end
  endtask

  task automatic count_en(input int n, output int hi, output int neq);
    hi = 0;
    neq = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (en_a) hi++;
      if (en_a != en_b) neq++;
    end
  endtask

  // Leg overlap monitor on every falling edge.
  always @(negedge clk) begin
    if (!reset && ((in1 && in2) || (in3 && in4))) begin
      checks++;
      errors++;
      $display("FAIL leg_overlap actual=%b expected=no_overlap", {in1, in2, in3, in4});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, neq;

    vecs[0] = '{cmd: 4'b0001, legs: 4'b1010, st: 2'b01};
    vecs[1] = '{cmd: 4'b0010, legs: 4'b0101, st: 2'b01};
    vecs[2] = '{cmd: 4'b0100, legs: 4'b1001, st: 2'b01};
    vecs[3] = '{cmd: 4'b1000, legs: 4'b0110, st: 2'b01};
    vecs[4] = '{cmd: 4'b0011, legs: 4'b0000, st: 2'b00};
    vecs[5] = '{cmd: 4'b1111, legs: 4'b0000, st: 2'b00};
    vecs[6] = '{cmd: 4'b0000, legs: 4'b0000, st: 2'b00};

    reset = 1'b1;
    motiondir = 4'b0000;
    duty = 8'd128;
    tick(); tick(); tick();
    chk("reset_legs", legs(), 4'b0000);
    chk("reset_en", {en_a, en_b}, 2'b00);
    chk("reset_state", state, 2'b00);
    chk("reset_busy", busy, 1'b0);
    reset = 1'b0;
    tick(); tick();

    // Table: from IDLE, each command appears on the third edge.
    for (int i = 0; i < 7; i++) begin
      motiondir = vecs[i].cmd;
      tick(); tick();
      chk("latency_idle", state, 2'b00);
      tick();
      chk("vec_legs", legs(), vecs[i].legs);
      chk("vec_state", state, vecs[i].st);
      motiondir = 4'b0000;
      for (int k = 0; k < 10; k++) tick();
      chk("vec_back_idle", state, 2'b00);
    end

    // Reset mid-RUN with 50% duty.
    motiondir = 4'b0001;
    tick(); tick(); tick();
    chk("run_fwd_legs", legs(), 4'b1010);
    chk("run_fwd_state", state, 2'b01);
    count_en(256, hi, neq);
    chk("duty128_high", hi, 128);
    reset = 1'b1;
    #1;
    chk("async_rst_legs", legs(), 4'b0000);
    chk("async_rst_en", {en_a, en_b}, 2'b00);
    chk("async_rst_state", state, 2'b00);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    chk("post_rst_idle", state, 2'b00);
    tick();
    chk("post_rst_legs", legs(), 4'b1010);
    chk("post_rst_state", state, 2'b01);

    // Forward to back: exactly 4 coast cycles.
    motiondir = 4'b0010;
    tick(); tick();
    chk("pre_coast_legs", legs(), 4'b1010);
    tick();
    chk("coast_state", state, 2'b10);
    count_coast(n);
    chk("coast_len_fb", n, 4);
    chk("back_legs", legs(), 4'b0101);
    chk("back_state", state, 2'b01);

    // Back to forward, then fwd -> right -> fwd during COAST (6 cycles).
    motiondir = 4'b0001;
    tick(); tick(); tick();
    count_coast(n);
    chk("coast_len_bf", n, 4);
    chk("fwd_again_legs", legs(), 4'b1010);
    motiondir = 4'b0100;
    tick(); tick();
    motiondir = 4'b0001;
    tick();
    chk("coast_restart_state", state, 2'b10);
    count_coast(n);
    chk("coast_len_restart", n, 6);
    chk("restart_legs", legs(), 4'b1010);
    chk("restart_state", state, 2'b01);

    // Illegal code acts as stop: COAST 4 then IDLE.
    motiondir = 4'b0011;
    tick(); tick(); tick();
    count_coast(n);
    chk("coast_len_stop", n, 4);
    chk("stop_state", state, 2'b00);
    chk("stop_legs", legs(), 4'b0000);
    chk("stop_busy", busy, 1'b0);

    // From IDLE to left: no COAST.
    motiondir = 4'b1000;
    tick(); tick();
    chk("left_pre_state", state, 2'b00);
    tick();
    chk("left_legs", legs(), 4'b0110);
    chk("left_state", state, 2'b01);
    chk("left_busy", busy, 1'b0);

    // Left to right, then PWM extremes with en_a == en_b.
    motiondir = 4'b0100;
    tick(); tick(); tick();
    count_coast(n);
    chk("coast_len_lr", n, 4);
    chk("right_legs", legs(), 4'b1001);
    duty = 8'd0;
    tick(); tick();
    count_en(512, hi, neq);
    chk("duty0_high", hi, 0);
    chk("duty0_en_eq", neq, 0);
    duty = 8'd255;
    tick(); tick();
    count_en(256, hi, neq);
    chk("duty255_high", hi, 255);
    chk("duty255_en_eq", neq, 0);
    duty = 8'd64;
    tick(); tick();
    count_en(256, hi, neq);
    chk("duty64_high", hi, 64);
    chk("duty64_en_eq", neq, 0);
    chk("right_legs_end", legs(), 4'b1001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_driver.md
Name: motor_driver

Overview:
- Consumes the one-hot motion command from the switch decoder and drives a dual H-bridge for a differential-drive robot.
- Left bridge: in1/in2/en_a. Right bridge: in3/in4/en_b.
- Synchronises the command and applies speed PWM on the enables.
- On any direction change, inserts a coast dead-time so no bridge leg reverses while energised.

Parameters:
- PWM_BITS, 8, width of the free-running PWM counter and of the duty input.
- DEADTIME, 50000, coast duration in clk cycles on command change; legal range 1 to 2^20-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- motiondir  input  4  one-hot command: 0001 fwd, 0010 back, 0100 turn right, 1000 turn left, 0000 stop; asynchronous to clk.
- duty  input  PWM_BITS  speed; enables high while pwm_cnt < duty.
- in1  output  1  left motor forward leg.
- in2  output  1  left motor reverse leg.
- in3  output  1  right motor forward leg.
- in4  output  1  right motor reverse leg.
- en_a  output  1  left bridge PWM enable.
- en_b  output  1  right bridge PWM enable.
- state  output  2  00 IDLE, 01 RUN, 10 COAST.
- busy  output  1  high while in COAST.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - all outputs to 0;
  - sync flops to 0000;
  - the active command register to stop;
  - pwm_cnt to 0;
  - the dead-time counter to 0;
  - state to IDLE.
  Reset mid-COAST or mid-RUN drops every output low immediately, without waiting for a clock edge.
- Input synchronisation: two-flop synchroniser on motiondir (s1, then s2).
  - Decoding uses s2 only.
  - Any s2 value that is not one of the five legal codes is treated as stop.
- Output mapping from the active command (in1,in2,in3,in4):
  - fwd: 1010.
  - back: 0101.
  - turn right: 1001 (left forward, right reverse).
  - turn left: 0110.
  - stop: 0000.
- PWM:
  - pwm_cnt is free-running, wraps from 2^PWM_BITS-1 to 0, and is never reset by state changes.
  - In RUN, en_a = en_b = registered (pwm_cnt < duty).
  - duty = 0 gives en constant low; duty = 2^PWM_BITS-1 gives en low for exactly 1 count per period.
  - duty changes take effect on the next clock; there is no glitch protection.
- FSM:
  - IDLE:
    - Outputs 0.
    - If decoded s2 is a motion command: load it as active, go to RUN.
    - in1..in4 become valid on the 3rd rising edge after motiondir changes (s1, s2, state).
  - RUN:
    - in1..in4 are driven from the active command; en_a/en_b carry PWM.
    - If decoded s2 differs from the active command, including stop: go to COAST and load the dead-time counter with DEADTIME-1.
  - COAST:
    - in1..in4 = 0, en_a = en_b = 0, busy = 1.
    - The counter decrements each cycle.
    - If decoded s2 changes during COAST, the counter reloads DEADTIME-1; the full dead-time restarts.
    - At count 0, the decoded s2 present on that cycle is loaded as active. Stop goes to IDLE; a motion command goes to RUN.
    - A command returning to its pre-COAST value still completes the full dead-time.
    - COAST therefore lasts exactly DEADTIME cycles when the input is stable.
- Outputs are registered; no combinational path from motiondir or duty to any output.
- At no time may in1&in2 or in3&in4 both be 1.

Test Plan:
- Reset mid-RUN (DEADTIME=4, duty=128): motiondir=0001, wait 3 edges -> in=1010, state=01, en toggles 50%. Assert reset -> all outputs 0 immediately; after release with motiondir still 0001 -> RUN again 3 edges later.
- Forward to back with DEADTIME=4: motiondir 0001 to 0010 -> state=10, busy=1, in/en=0 for exactly 4 cycles, then in=0101, state=01; no cycle shows a leg overlap.
- Change during COAST: 0001, then 0100, then 0001 again 2 cycles into COAST -> counter restarts, COAST lasts 2+4 cycles total, then RUN with in=1010.
- Stop and illegal codes: RUN fwd, apply 0011 -> COAST 4 cycles then IDLE, outputs 0000. From IDLE, apply 1000 -> in=0110 on the 3rd edge with no COAST.
- PWM extremes (PWM_BITS=8): duty=0 -> en_a/en_b never high over 512 cycles. duty=255 -> exactly 1 low cycle per 256. duty=64 -> 64 high per 256.
- Turn-right mapping: motiondir=0100 -> in=1001 with en_a == en_b every cycle.
